// File: rtl/apb_cmd_arbiter.sv
// apb_cmd_arbiter: round-robin sharing of one APB master command port between NREQ requesters,
// with latched commands, read-data return, done pulse and optional completion timeout.
module apb_cmd_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*WIDTH-1:0]  req_addr,
  input  logic [NREQ*WIDTH-1:0]  req_wdata,
  input  logic [NREQ*SEL_W-1:0]  req_sel,
  input  logic [NREQ-1:0]        req_wr,
  output logic [NREQ-1:0]        req_done,
  output logic                   req_err,
  output logic [WIDTH-1:0]       req_rdata,
  output logic [WIDTH-1:0]       p_addr,
  output logic [WIDTH-1:0]       pw_data,
  output logic [SEL_W-1:0]       p_sel,
  output logic                   p_wr,
  output logic                   trans,
  input  logic                   m_pready,
  input  logic                   m_en,
  input  logic [WIDTH-1:0]       m_prdata,
  output logic                   busy
);
  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_ptr, r_gnt, w_gnt;
  logic [IDX_W:0]   w_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cmp, w_tmo;

  assign w_cmp = m_pready & m_en;
  assign w_tmo = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  // Scan offsets high-to-low so the offset closest to the pointer wins last.
  always_comb begin
    w_gnt = '0;
    w_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NREQ)) w_sum = w_sum - (IDX_W+1)'(NREQ);
      if (req_valid[w_sum[IDX_W-1:0]]) w_gnt = w_sum[IDX_W-1:0];
    end
  end

  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) r_state <= IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state == IDLE  ? (|req_valid ? ISSUE : IDLE) :
             r_state == ISSUE ? WAIT :
             r_state == WAIT  ? ((w_cmp || w_tmo) ? DONE : WAIT) : IDLE;
    trans    = r_state == ISSUE || r_state == WAIT;
    busy     = r_state != IDLE;
    req_done = r_state == DONE ? NREQ'(1) << r_gnt : '0;
  end

  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      r_gnt     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      p_addr    <= '0;
      pw_data   <= '0;
      p_sel     <= '0;
      p_wr      <= 1'b0;
      req_rdata <= '0;
      req_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && |req_valid) begin
        r_gnt   <= w_gnt;
        p_addr  <= req_addr[w_gnt*WIDTH +: WIDTH];
        pw_data <= req_wdata[w_gnt*WIDTH +: WIDTH];
        p_sel   <= req_sel[w_gnt*SEL_W +: SEL_W];
        p_wr    <= req_wr[w_gnt];
      end
      r_cnt <= r_state == WAIT ? r_cnt + 1'b1 : '0;
      // Completion takes precedence over a coincident timeout.
      if (r_state == WAIT && (w_cmp || w_tmo)) begin
        req_rdata <= (w_cmp && !p_wr) ? m_prdata : '0;
        req_err   <= !w_cmp;
      end
      if (r_state == DONE) r_ptr <= r_gnt == IDX_W'(NREQ - 1) ? '0 : r_gnt + 1'b1;
    end
endmodule

// File: doc/apb_cmd_arbiter.md
Name: apb_cmd_arbiter

Overview:
Round-robin arbiter that shares the single APB master command port (p_addr/pw_data/p_sel/p_wr/trans) between NREQ independent requesters, e.g. a baud-rate configurator, a TX byte pusher and a status poller for the UART slave. It latches the winning request, drives the master until completion (m_pready & m_en), returns read data and a done pulse to the winner, and aborts hung transfers with a timeout. It sits between the requester logic and the APB master.

Parameters:
WIDTH, 32, address/data width (matches `WIDTH)
NREQ, 4, number of requesters (2..8)
SEL_W, 4, width of p_sel
TIMEOUT, 256, max cycles waiting for completion; 0 disables timeout

Ports:
pclk  in  1  clock
presetn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request; held high with fields stable until req_done
req_addr  in  NREQ*WIDTH  flattened addresses, requester i at [i*WIDTH +: WIDTH]
req_wdata  in  NREQ*WIDTH  flattened write data
req_sel  in  NREQ*SEL_W  flattened slave selects
req_wr  in  NREQ  1=write, 0=read
req_done  out  NREQ  one-cycle completion pulse to the granted requester
req_err  out  1  qualifies req_done: 1=timed out
req_rdata  out  WIDTH  read data, valid in the req_done cycle
p_addr  out  WIDTH  command address to master
pw_data  out  WIDTH  command write data
p_sel  out  SEL_W  command slave select
p_wr  out  1  command direction
trans  out  1  transfer request to master
m_pready  in  1  slave ready from master
m_en  in  1  master ACCESS-phase enable
m_prdata  in  WIDTH  read data from master
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (presetn=0, async): state=IDLE, rr pointer=0, timeout counter=0; all outputs 0.
- FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: if any req_valid, pick first set bit searching from rr pointer upward with wrap (pointer itself highest priority); latch index g and its addr/wdata/sel/wr into command registers; go ISSUE. No valid: stay.
- ISSUE (1 cycle): trans=1, p_* = latched command; counter cleared; go WAIT.
- WAIT: trans and p_* held. On cycle with m_pready & m_en sampled high: capture m_prdata (reads) or 0 (writes) into req_rdata; go DONE. If TIMEOUT!=0 and counter reaches TIMEOUT-1 without completion: req_rdata=0, set err flag, go DONE. Counter increments each WAIT cycle.
- DONE (1 cycle): trans=0; req_done[g]=1, req_err=err flag; rr pointer = (g+1) mod NREQ; go IDLE. Guarantees >=1 idle cycle between transfers.
- Latency: request sampled in IDLE at cycle N -> trans=1 at N+1; completion seen at cycle C -> req_done at C+1. Minimum request-to-done = 4 cycles.
- Command registers are latched once; requester field changes after grant are ignored.
- req_valid[g] dropping mid-transfer: transfer still completes and req_done[g] still pulses.
- Requests arriving during ISSUE/WAIT/DONE wait; arbitration only in IDLE.
- Completion and timeout in the same cycle: completion wins, req_err=0.
- m_pready & m_en outside WAIT: ignored.
- req_rdata/req_err hold their value until next DONE; req_done is the only qualifier.
- Reset mid-transfer: immediate return to IDLE, outputs 0, no req_done issued.

Test Plan:
- Single write: req 1 writes addr DVSR data 0x145 -> trans high one cycle after valid, p_addr=DVSR, pw_data=0x145, p_wr=1; req_done=4'b0010 one cycle after m_pready&m_en, req_err=0.
- Read: req 2 reads TX_BUSY, slave returns 0x1 -> req_rdata=0x1 with req_done[2]; p_wr=0 throughout.
- Fairness: all four req_valid held high, 8 transfers -> grant order 0,1,2,3,0,1,2,3; trans low >=1 cycle between each.
- Timeout: TIMEOUT=16, m_pready held 0 -> req_done pulses 17 cycles after ISSUE with req_err=1, req_rdata=0; next request served normally.
- Reset mid-WAIT: presetn low during transfer -> trans, busy, req_done all 0 immediately; after release, pending req_valid[3] with pointer=0 -> req 3 granted (only valid).
- Field change after grant: req 0 changes req_addr in WAIT -> p_addr keeps original value until DONE.
